// File: rtl/qgate_pkg.sv
// Shared constants for the single-qubit gate sequencer: gate codes,
// Q16.16 fixed-point constants and the sequencer FSM state encoding.
package qgate_pkg;

   localparam int unsigned GATE_W = 3;

   localparam logic [GATE_W-1:0] GATE_IDLE = 3'b000;
   localparam logic [GATE_W-1:0] GATE_H    = 3'b001;
   localparam logic [GATE_W-1:0] GATE_X    = 3'b010;
   localparam logic [GATE_W-1:0] GATE_Z    = 3'b011;
   localparam logic [GATE_W-1:0] GATE_Y    = 3'b100;

   localparam logic signed [31:0] FIXED_ONE  = 32'sh0001_0000;
   localparam logic signed [31:0] FIXED_ZERO = 32'sh0000_0000;
   localparam logic signed [31:0] INV_SQRT2  = 32'sh0000_B504;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/quantum_gate.sv
// Combinational single-qubit gate datapath on signed Q16.16 amplitudes.
// Y is applied with its global phase dropped: (a, b) -> (-b, a).
module quantum_gate
   import qgate_pkg::*;
#(
   parameter int unsigned DATA_W = 32
)(
   input  logic [GATE_W-1:0]        i_gate,
   input  logic signed [DATA_W-1:0] i_alpha,
   input  logic signed [DATA_W-1:0] i_beta,
   output logic signed [DATA_W-1:0] o_alpha,
   output logic signed [DATA_W-1:0] o_beta
);

   localparam int unsigned SW = DATA_W + 1;
   localparam int unsigned PW = 2 * DATA_W + 1;
   localparam logic signed [PW-1:0] MAX_V = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_diff;
   logic signed [SW-1:0] w_neg_a;
   logic signed [SW-1:0] w_neg_b;
   logic signed [PW-1:0] w_h0;
   logic signed [PW-1:0] w_h1;

   // Clamp a wide signed intermediate into the DATA_W amplitude range
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
      if (v > MAX_V)      sat = DATA_W'(MAX_V);
      else if (v < MIN_V) sat = DATA_W'(MIN_V);
      else                sat = DATA_W'(v);
   endfunction

   // Widened sums, differences and negations so nothing wraps before clamping
   always_comb begin
      w_sum   = SW'(i_alpha) + SW'(i_beta);
      w_diff  = SW'(i_alpha) - SW'(i_beta);
      w_neg_a = -SW'(i_alpha);
      w_neg_b = -SW'(i_beta);
      w_h0    = (PW'(w_sum)  * PW'(INV_SQRT2)) >>> 16;
      w_h1    = (PW'(w_diff) * PW'(INV_SQRT2)) >>> 16;
   end

   // Gate select; idle and unassigned codes pass amplitudes through
   always_comb begin
      o_alpha = i_alpha;
      o_beta  = i_beta;
      case (i_gate)
         GATE_H: begin
            o_alpha = sat(w_h0);
            o_beta  = sat(w_h1);
         end
         GATE_X: begin
            o_alpha = i_beta;
            o_beta  = i_alpha;
         end
         GATE_Z: begin
            o_beta  = sat(PW'(w_neg_b));
         end
         GATE_Y: begin
            o_alpha = sat(PW'(w_neg_b));
            o_beta  = i_alpha;
         end
         default: begin
            o_alpha = i_alpha;
            o_beta  = i_beta;
         end
      endcase
   end

endmodule

// File: rtl/qgate_sequencer.sv
// Queues single-qubit gate ops and applies them one per cycle to a
// registered amplitude pair, with IDLE/RUN/DONE control.
module qgate_sequencer
   import qgate_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              init_valid,
   input  logic [DATA_W-1:0] init_alpha,
   input  logic [DATA_W-1:0] init_beta,
   input  logic              op_valid,
   input  logic [2:0]        op_gate,
   output logic              op_ready,
   input  logic              start,
   input  logic              abort,
   output logic [DATA_W-1:0] alpha_q,
   output logic [DATA_W-1:0] beta_q,
   output logic              busy,
   output logic              done,
   output logic [7:0]        gate_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   state_t             r_state;
   logic [GATE_W-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               r_op_ready;
   logic [DATA_W-1:0]  r_alpha;
   logic [DATA_W-1:0]  r_beta;
   logic               r_busy;
   logic               r_done;
   logic [7:0]         r_gate_count;

   logic               w_ctrl_ok;
   logic               w_push;
   logic               w_pop;
   logic               w_start;
   logic               w_init;
   logic [CW-1:0]      w_count_next;
   logic [DATA_W-1:0]  w_alpha_g;
   logic [DATA_W-1:0]  w_beta_g;

   // Handshake decode; abort wins over push, pop and start
   assign w_ctrl_ok    = (r_state != ST_RUN);
   assign w_push       = op_valid && r_op_ready && !abort;
   assign w_pop        = (r_state == ST_RUN) && !abort && (r_count != '0);
   assign w_start      = start && w_ctrl_ok && !abort;
   assign w_init       = init_valid && w_ctrl_ok;
   assign w_count_next = abort ? '0 : CW'(r_count + CW'(w_push) - CW'(w_pop));

   quantum_gate #(
      .DATA_W (DATA_W)
   ) u_gate (
      .i_gate  (r_mem[r_rd_ptr]),
      .i_alpha (r_alpha),
      .i_beta  (r_beta),
      .o_alpha (w_alpha_g),
      .o_beta  (w_beta_g)
   );

   // Queue storage; contents are don't-care once pointers are reset
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr] <= op_gate;
   end

   // Queue pointers, control FSM and registered amplitude/status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_op_ready   <= 1'b1;
         r_alpha      <= DATA_W'(FIXED_ONE);
         r_beta       <= DATA_W'(FIXED_ZERO);
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_gate_count <= '0;
      end else begin
         r_done     <= 1'b0;
         r_count    <= w_count_next;
         r_op_ready <= (w_count_next != CW'(FIFO_DEPTH));
         if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case (r_state)
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_pop) begin
                  r_alpha <= w_alpha_g;
                  r_beta  <= w_beta_g;
                  if (r_gate_count != 8'hFF) r_gate_count <= r_gate_count + 8'd1;
                  if (w_count_next == '0) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               if (w_init) begin
                  r_alpha <= init_alpha;
                  r_beta  <= init_beta;
               end
               if (w_start) begin
                  r_gate_count <= '0;
                  if (r_count != '0) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign op_ready   = r_op_ready;
   assign alpha_q    = r_alpha;
   assign beta_q     = r_beta;
   assign busy       = r_busy;
   assign done       = r_done;
   assign gate_count = r_gate_count;

endmodule
